// File: rtl/simmem_resp_releaser.sv
// Per-ID release scheduler: counts down delay-tagged descriptors and raises per-(type, id)
// release enables once a slot expires; bank acknowledges retire expired slots.
module simmem_resp_releaser #(
  parameter int unsigned IDWidth    = 4,
  parameter int unsigned NumSlots   = 8,
  parameter int unsigned DelayWidth = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                req_valid_i,
  output logic                                req_ready_o,
  input  logic                                req_type_i,
  input  logic [IDWidth-1:0]                  req_id_i,
  input  logic [DelayWidth-1:0]               req_delay_i,
  output logic [1:0][2**IDWidth-1:0]          release_en_o,
  input  logic [1:0]                          rel_ack_valid_i,
  input  logic [1:0][IDWidth-1:0]             rel_ack_id_i,
  output logic                                err_o
);

  localparam logic [DelayWidth-1:0] CntOne = 1;

  logic [NumSlots-1:0]   valid_q, valid_d;
  logic [NumSlots-1:0]   type_q, type_d;
  logic [IDWidth-1:0]    id_q [NumSlots];
  logic [IDWidth-1:0]    id_d [NumSlots];
  logic [DelayWidth-1:0] cnt_q [NumSlots];
  logic [DelayWidth-1:0] cnt_d [NumSlots];
  logic                  err_q, err_d;

  logic [NumSlots-1:0]      expired;
  logic [DelayWidth-1:0]    cnt_dec [NumSlots];
  logic [NumSlots-1:0]      alloc_oh;
  logic                     alloc_found;
  logic                     accept;
  logic [DelayWidth-1:0]    eff;
  logic [1:0][NumSlots-1:0] ack_oh;
  logic [1:0]               ack_hit;

  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      expired[i] = valid_q[i] && (cnt_q[i] == '0);
      cnt_dec[i] = (cnt_q[i] == '0) ? '0 : cnt_q[i] - CntOne;
    end
  end

  assign req_ready_o = ~&valid_q;
  assign accept      = req_valid_i && req_ready_o;
  assign err_o       = err_q;

  always_comb begin
    release_en_o = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (expired[i]) release_en_o[type_q[i]][id_q[i]] = 1'b1;
    end
  end

  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < NumSlots; i++) begin
      if (!valid_q[i] && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  // Matching slots contribute their next-cycle count so the new entry expires no earlier
  // than any older same-(type, id) entry.
  always_comb begin
    eff = req_delay_i;
    for (int i = 0; i < NumSlots; i++) begin
      if (valid_q[i] && (type_q[i] == req_type_i) && (id_q[i] == req_id_i) &&
          (cnt_dec[i] > eff)) begin
        eff = cnt_dec[i];
      end
    end
  end

  always_comb begin
    ack_oh  = '0;
    ack_hit = '0;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < NumSlots; i++) begin
        if (rel_ack_valid_i[t] && !ack_hit[t] && expired[i] &&
            (type_q[i] == (t != 0)) && (id_q[i] == rel_ack_id_i[t])) begin
          ack_oh[t][i] = 1'b1;
          ack_hit[t]   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    type_d  = type_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    err_d   = err_q | (rel_ack_valid_i[0] & ~ack_hit[0]) | (rel_ack_valid_i[1] & ~ack_hit[1]);
    for (int i = 0; i < NumSlots; i++) begin
      if (valid_q[i]) cnt_d[i] = cnt_dec[i];
      if (ack_oh[0][i] || ack_oh[1][i]) valid_d[i] = 1'b0;
      if (accept && alloc_oh[i]) begin
        valid_d[i] = 1'b1;
        type_d[i]  = req_type_i;
        id_d[i]    = req_id_i;
        cnt_d[i]   = eff;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      type_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NumSlots; i++) begin
        id_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      type_q  <= type_d;
      err_q   <= err_d;
      for (int i = 0; i < NumSlots; i++) begin
        id_q[i]  <= id_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_simmem_resp_releaser.sv
// Bench for simmem_resp_releaser: directed scenarios plus random traffic, checked every cycle
// against a model that tracks absolute expiry times per scheduled response.
module tb_simmem_resp_releaser;

  localparam int NS = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic             req_type_i = 1'b0;
  logic [3:0]       req_id_i = '0;
  logic [7:0]       req_delay_i = '0;
  logic [1:0][15:0] release_en_o;
  logic [1:0]       rel_ack_valid_i = '0;
  logic [1:0][3:0]  rel_ack_id_i = '0;
  logic             err_o;

  always #5 clk = ~clk;

  simmem_resp_releaser #(
    .IDWidth   (4),
    .NumSlots  (NS),
    .DelayWidth(8)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_type_i     (req_type_i),
    .req_id_i       (req_id_i),
    .req_delay_i    (req_delay_i),
    .release_en_o   (release_en_o),
    .rel_ack_valid_i(rel_ack_valid_i),
    .rel_ack_id_i   (rel_ack_id_i),
    .err_o          (err_o)
  );

  // Model: each scheduled response has an absolute cycle from which it is releasable.
  bit m_valid [NS];
  bit m_type  [NS];
  int m_id    [NS];
  int m_exp   [NS];
  bit m_err;
  int cyc;
  bit last_acc;
  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_rel();
    logic [31:0] r = '0;
    for (int i = 0; i < NS; i++)
      if (m_valid[i] && m_exp[i] <= cyc) r[m_type[i] * 16 + m_id[i]] = 1'b1;
    return r;
  endfunction

  function automatic logic model_ready();
    logic r = 1'b0;
    for (int i = 0; i < NS; i++) if (!m_valid[i]) r = 1'b1;
    return r;
  endfunction

  function automatic bit model_any();
    bit r = 0;
    for (int i = 0; i < NS; i++) if (m_valid[i]) r = 1;
    return r;
  endfunction

  // Called just after a falling edge: check this cycle's outputs, drive, advance one cycle.
  task automatic step(input bit v, input bit t, input int id, input int d,
                      input bit [1:0] av, input int a0, input int a1);
    bit clr [NS];
    bit found;
    int aid, e, slot;
    check("release_en", release_en_o, model_rel());
    check("req_ready", req_ready_o, model_ready());
    check("err", err_o, m_err);
    req_valid_i        = v;
    req_type_i         = t;
    req_id_i           = id[3:0];
    req_delay_i        = d[7:0];
    rel_ack_valid_i    = av;
    rel_ack_id_i[0]    = a0[3:0];
    rel_ack_id_i[1]    = a1[3:0];
    for (int i = 0; i < NS; i++) clr[i] = 0;
    for (int tt = 0; tt < 2; tt++) begin
      if (av[tt]) begin
        aid   = (tt == 1) ? a1 : a0;
        found = 0;
        for (int i = 0; i < NS; i++) begin
          if (!found && !clr[i] && m_valid[i] && m_type[i] == tt[0] && m_id[i] == aid &&
              m_exp[i] <= cyc) begin
            clr[i] = 1;
            found  = 1;
          end
        end
        if (!found) m_err = 1;
      end
    end
    last_acc = 0;
    if (v) begin
      slot = -1;
      for (int i = NS - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
      if (slot >= 0) begin
        e = cyc + 1 + d;
        for (int i = 0; i < NS; i++)
          if (m_valid[i] && m_type[i] == t && m_id[i] == id && m_exp[i] > e) e = m_exp[i];
        m_valid[slot] = 1;
        m_type[slot]  = t;
        m_id[slot]    = id;
        m_exp[slot]   = e;
        last_acc      = 1;
      end
    end
    for (int i = 0; i < NS; i++) if (clr[i]) m_valid[i] = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  // Acknowledge every expired response until the model is empty (bounded).
  task automatic drain();
    bit [1:0] av;
    int a [2];
    for (int n = 0; n < 400 && model_any(); n++) begin
      av = '0;
      a[0] = 0;
      a[1] = 0;
      for (int i = NS - 1; i >= 0; i--) begin
        if (m_valid[i] && m_exp[i] <= cyc) begin
          av[m_type[i]] = 1'b1;
          a[m_type[i]]  = m_id[i];
        end
      end
      step(0, 0, 0, 0, av, a[0], a[1]);
    end
    check("drain_ready", req_ready_o, 1);
  endtask

  task automatic random_phase(input int ncyc);
    bit p_v = 0, p_t = 0;
    int p_id = 0, p_d = 0;
    bit [1:0] av;
    int a [2];
    int cand [$];
    for (int n = 0; n < ncyc; n++) begin
      if (!p_v && ($urandom % 3 == 0)) begin
        p_v  = 1;
        p_t  = 1'($urandom % 2);
        p_id = $urandom % 4;
        p_d  = ($urandom % 8 == 0) ? $urandom % 60 : $urandom % 12;
      end
      for (int tt = 0; tt < 2; tt++) begin
        cand.delete();
        for (int i = 0; i < NS; i++)
          if (m_valid[i] && m_type[i] == tt[0] && m_exp[i] <= cyc) cand.push_back(m_id[i]);
        av[tt] = (cand.size() > 0) && ($urandom % 2 == 0);
        a[tt]  = (cand.size() > 0) ? cand[$urandom % cand.size()] : 0;
      end
      step(p_v, p_t, p_id, p_d, av, a[0], a[1]);
      if (last_acc) p_v = 0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    m_err    = 0;
    for (int i = 0; i < NS; i++) m_valid[i] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) idle();

    // Read id 3, delay 5: releasable exactly 6 cycles after the accept.
    step(1, 0, 3, 5, 2'b00, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      check("rd_latency", release_en_o[0][3], k >= 6);
      if (k == 8) step(0, 0, 0, 0, 2'b01, 3, 0);
      else idle();
    end
    check("rd_ack_drop", release_en_o[0][3], 0);

    // Same-ID ordering: younger short-delay write must not overtake the older one.
    step(1, 1, 2, 10, 2'b00, 0, 0);
    step(1, 1, 2, 2, 2'b00, 0, 0);
    for (int k = 2; k <= 12; k++) begin
      check("wr_order", release_en_o[1][2], k >= 11);
      if (k >= 11) step(0, 0, 0, 0, 2'b10, 0, 2);
      else idle();
    end
    check("wr_order_drop", release_en_o[1][2], 0);
    drain();

    // Fill every slot, then hold a ninth request until a slot is retired.
    for (int i = 0; i < NS; i++) step(1, 0, i, 50, 2'b00, 0, 0);
    check("full_ready", req_ready_o, 0);
    for (int n = 0; n < 80; n++) begin
      if (m_valid[0] && m_exp[0] <= cyc) begin
        check("full_ready_ack_cycle", req_ready_o, 0);
        step(1, 1, 5, 0, 2'b01, 0, 0);
        check("full_ready_after_ack", req_ready_o, 1);
        step(1, 1, 5, 0, 2'b00, 0, 0);
        check("full_again", req_ready_o, 0);
        break;
      end
      step(1, 1, 5, 0, 2'b00, 0, 0);
    end
    check("ninth_release", release_en_o[1][5], 1);
    drain();

    // Simultaneous acknowledges of both types.
    step(1, 0, 1, 0, 2'b00, 0, 0);
    step(1, 1, 1, 0, 2'b00, 0, 0);
    idle();
    check("sim_rd_high", release_en_o[0][1], 1);
    check("sim_wr_high", release_en_o[1][1], 1);
    step(0, 0, 0, 0, 2'b11, 1, 1);
    check("sim_rd_drop", release_en_o[0][1], 0);
    check("sim_wr_drop", release_en_o[1][1], 0);
    check("sim_err", err_o, 0);

    random_phase(1500);
    drain();

    // Stray acknowledge sets the sticky error; asynchronous reset clears everything.
    step(1, 0, 4, 0, 2'b00, 0, 0);
    step(1, 1, 6, 30, 2'b00, 0, 0);
    step(0, 0, 0, 0, 2'b01, 7, 0);
    check("err_set", err_o, 1);
    check("err_slot_kept", release_en_o[0][4], 1);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_err", err_o, 0);
    check("rst_release", release_en_o, 0);
    check("rst_ready", req_ready_o, 1);
    for (int i = 0; i < NS; i++) m_valid[i] = 0;
    m_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) idle();
    step(1, 0, 9, 1, 2'b00, 0, 0);
    idle();
    check("post_rst_release", release_en_o[0][9], 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
